// File: rtl/adder_bist_pkg.sv
// Shared definitions for the adder BIST harness: state encoding, LFSR taps,
// counter width and helpers used by the harness and its LFSR.
package adder_bist_pkg;

  localparam int COUNT_W = 32;

  // Taps for x^64 + x^63 + x^61 + x^60 + 1 (bits 63, 62, 60, 59).
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  // first_fail_idx value meaning "no failure recorded".
  localparam logic [COUNT_W-1:0] FAIL_IDX_NONE = {COUNT_W{1'b1}};

  // FSM state encoding.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_CHECK  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  // One Fibonacci step: shift left, XOR of taps enters bit 0.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], ^(s & LFSR_TAPS)};
  endfunction

  // Zero is a lock-up state for this LFSR, so it is replaced by 1.
  function automatic logic [63:0] fix_seed(input logic [63:0] s);
    return (s == 64'h0) ? 64'h1 : s;
  endfunction

  // Saturating counter increment; sticks at all ones.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (c == FAIL_IDX_NONE) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Bus between the BIST harness and its environment: run control, AUT
// operand/sum path and the result/statistics outputs.
interface adder_bist_if
  import adder_bist_pkg::*;
#(
  parameter int WIDTH = 64
);
  logic               start;
  logic [WIDTH-1:0]   aut_a;
  logic [WIDTH-1:0]   aut_b;
  logic [WIDTH-1:0]   aut_sum;
  logic               busy;
  logic               done;
  logic               all_pass;
  logic [COUNT_W-1:0] pass_count;
  logic [COUNT_W-1:0] fail_count;
  logic [COUNT_W-1:0] first_fail_idx;
  logic [WIDTH-1:0]   first_fail_sum;

  // Harness side: drives operands and results.
  modport master (
    input  start, aut_sum,
    output aut_a, aut_b, busy, done, all_pass,
           pass_count, fail_count, first_fail_idx, first_fail_sum
  );

  // Environment side: launches runs, returns the AUT sum, reads results.
  modport slave (
    output start, aut_sum,
    input  aut_a, aut_b, busy, done, all_pass,
           pass_count, fail_count, first_fail_idx, first_fail_sum
  );
endinterface

// File: rtl/bist_lfsr64.sv
// 64-bit Fibonacci LFSR that advances two steps at a time so one operand
// pair (q, q_next) is available per vector.
module bist_lfsr64
  import adder_bist_pkg::*;
#(
  parameter logic [63:0] RST_SEED = 64'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        step2,
  output logic [63:0] q,
  output logic [63:0] q_next
);

  logic [63:0] lfsr_q, lfsr_d;

  assign q      = lfsr_q;
  assign q_next = lfsr_step(lfsr_q);

  // Reseed takes priority over stepping; otherwise hold.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = fix_seed(seed);
    end else if (step2) begin
      lfsr_d = lfsr_step(q_next);
    end
  end

  // State register, reset to the (zero-corrected) seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= fix_seed(RST_SEED);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/adder_bist_harness.sv
// Self-test harness for an external adder: applies LFSR operand pairs,
// waits a settle time, compares against a reference sum and keeps stats.
module adder_bist_harness
  import adder_bist_pkg::*;
#(
  parameter int          WIDTH         = 64,
  parameter logic [31:0] NUM_TESTS     = 32'd10000,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [63:0] SEED          = 64'h5
) (
  input logic          clk,
  input logic          rst,
  adder_bist_if.master bus
);

  state_t             state_q, state_d;
  logic [31:0]        settle_q, settle_d;
  logic [COUNT_W-1:0] idx_q, idx_d;
  logic [COUNT_W-1:0] pass_q, pass_d;
  logic [COUNT_W-1:0] fail_q, fail_d;
  logic [COUNT_W-1:0] ffi_q, ffi_d;
  logic [WIDTH-1:0]   ffs_q, ffs_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               allp_q, allp_d;

  logic               lfsr_load, lfsr_step2;
  logic [63:0]        lfsr_q, lfsr_nxt;
  logic [WIDTH-1:0]   ref_sum;
  logic               unused_lfsr;

  bist_lfsr64 #(.RST_SEED(SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load   (lfsr_load),
    .seed   (SEED),
    .step2  (lfsr_step2),
    .q      (lfsr_q),
    .q_next (lfsr_nxt)
  );

  // Upper LFSR bits are not needed for narrow adders.
  assign unused_lfsr = ^{lfsr_q, lfsr_nxt};

  // Reference sum wraps modulo 2^WIDTH; carry-out is intentionally dropped.
  assign ref_sum = a_q + b_q;

  assign bus.aut_a          = a_q;
  assign bus.aut_b          = b_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.all_pass       = allp_q;
  assign bus.pass_count     = pass_q;
  assign bus.fail_count     = fail_q;
  assign bus.first_fail_idx = ffi_q;
  assign bus.first_fail_sum = ffs_q;

  // Next-state logic for the FSM, operands and statistics.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    ffi_d      = ffi_q;
    ffs_d      = ffs_q;
    a_d        = a_q;
    b_d        = b_q;
    busy_d     = busy_q;
    done_d     = done_q;
    allp_d     = allp_q;
    lfsr_load  = 1'b0;
    lfsr_step2 = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          allp_d = (fail_q == '0);
        end
        // start is only honoured when no run is in progress.
        if (bus.start) begin
          state_d   = ST_LOAD;
          idx_d     = '0;
          pass_d    = '0;
          fail_d    = '0;
          ffi_d     = FAIL_IDX_NONE;
          ffs_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          allp_d    = 1'b0;
          lfsr_load = 1'b1;
        end
      end
      ST_LOAD: begin
        a_d        = lfsr_q[WIDTH-1:0];
        b_d        = lfsr_nxt[WIDTH-1:0];
        lfsr_step2 = 1'b1;
        settle_d   = 32'(SETTLE_CYCLES - 1);
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == 32'd0) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q - 32'd1;
        end
      end
      ST_CHECK: begin
        if (bus.aut_sum == ref_sum) begin
          pass_d = sat_inc(pass_q);
        end else begin
          fail_d = sat_inc(fail_q);
          if (fail_q == '0) begin
            ffi_d = idx_q;
            ffs_d = bus.aut_sum;
          end
        end
        idx_d   = idx_q + 32'd1;
        state_d = (idx_d == NUM_TESTS) ? ST_DONE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // All state registers; reset aborts any run and clears all results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      idx_q    <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      ffi_q    <= FAIL_IDX_NONE;
      ffs_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      allp_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      ffi_q    <= ffi_d;
      ffs_q    <= ffs_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      allp_q   <= allp_d;
    end
  end

endmodule

// File: tb/tb_adder_bist_harness.sv
// Directed bench for adder_bist_harness: three harness instances (8-bit
// ideal AUT, 16-bit AUT with sum[0] stuck at 1, 64-bit with SEED=0).
module tb_adder_bist_harness;
  import adder_bist_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  adder_bist_if #(.WIDTH(8))  bus8 ();
  adder_bist_if #(.WIDTH(16)) bus16 ();
  adder_bist_if #(.WIDTH(64)) bus64 ();

  // AUT models: ideal (carry dropped by width), stuck-at-1 LSB, ideal.
  assign bus8.aut_sum  = bus8.aut_a + bus8.aut_b;
  assign bus16.aut_sum = (bus16.aut_a + bus16.aut_b) | 16'h0001;
  assign bus64.aut_sum = bus64.aut_a + bus64.aut_b;

  adder_bist_harness #(.WIDTH(8), .NUM_TESTS(32'd4), .SETTLE_CYCLES(2), .SEED(64'hFF)) u8 (
    .clk(clk), .rst(rst), .bus(bus8));
  adder_bist_harness #(.WIDTH(16), .NUM_TESTS(32'd100), .SETTLE_CYCLES(2), .SEED(64'h5)) u16 (
    .clk(clk), .rst(rst), .bus(bus16));
  adder_bist_harness #(.WIDTH(64), .NUM_TESTS(32'd3), .SETTLE_CYCLES(1), .SEED(64'h0)) u64 (
    .clk(clk), .rst(rst), .bus(bus64));

  // SEED=FF, no feedback in the first steps: LFSR low bytes FF,FE,FC,F8,F0,E0,C0,80.
  logic [7:0] exp_a8 [4] = '{8'hFF, 8'hFC, 8'hF0, 8'hC0};
  logic [7:0] exp_b8 [4] = '{8'hFE, 8'hF8, 8'hE0, 8'h80};
  logic [7:0] cap_a [4];
  logic [7:0] cap_b [4];

  // Pulse start on the 8-bit instance, record operands at each LOAD edge,
  // optionally re-pulse start after edge 'poke', and count edges to done.
  task automatic run8(input int poke, output int edges);
    int k;
    @(negedge clk); bus8.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus8.start = 1'b0;
    edges = 0;
    while (bus8.done !== 1'b1 && edges < 200) begin
      @(posedge clk); edges++;
      @(negedge clk);
      if (edges % 4 == 1 && edges < 17) begin
        k = edges / 4;
        cap_a[k[1:0]] = bus8.aut_a;
        cap_b[k[1:0]] = bus8.aut_b;
      end
      bus8.start = (edges == poke);
    end
    bus8.start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus8.busy, bus8.done, bus8.all_pass} !== 3'b000)
      $display("FAIL reset_flags8 got %b want 000", {bus8.busy, bus8.done, bus8.all_pass});
    else n_pass++;
    n_total++;
    if ({bus8.aut_a, bus8.aut_b} !== 16'h0000)
      $display("FAIL reset_ops8 got %h want 0000", {bus8.aut_a, bus8.aut_b});
    else n_pass++;
    n_total++;
    if ({bus8.pass_count, bus8.fail_count} !== 64'h0)
      $display("FAIL reset_counts8 got %h want 0", {bus8.pass_count, bus8.fail_count});
    else n_pass++;
    n_total++;
    if (bus8.first_fail_idx !== 32'hFFFFFFFF || bus8.first_fail_sum !== 8'h00)
      $display("FAIL reset_ff8 got idx=%h sum=%h want FFFFFFFF/00", bus8.first_fail_idx, bus8.first_fail_sum);
    else n_pass++;
    n_total++;
    if ({bus16.busy, bus16.done, bus16.all_pass, bus64.busy, bus64.done, bus64.all_pass} !== 6'b0)
      $display("FAIL reset_flags_other got %b want 000000",
               {bus16.busy, bus16.done, bus16.all_pass, bus64.busy, bus64.done, bus64.all_pass});
    else n_pass++;
    n_total++;
    if (bus64.aut_a !== 64'h0 || bus64.fail_count !== 32'h0 || bus64.first_fail_idx !== 32'hFFFFFFFF
        || bus64.first_fail_sum !== 64'h0 || bus16.pass_count !== 32'h0)
      $display("FAIL reset_other got a64=%h fail64=%h ffi64=%h ffs64=%h pass16=%h",
               bus64.aut_a, bus64.fail_count, bus64.first_fail_idx, bus64.first_fail_sum, bus16.pass_count);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_ideal();
    int e;
    run8(-1, e);
    n_total++;
    if (e !== 17) $display("FAIL ideal_latency got %0d edges want 17", e); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (cap_a[k[1:0]] !== exp_a8[k[1:0]] || cap_b[k[1:0]] !== exp_b8[k[1:0]])
        $display("FAIL ideal_ops[%0d] got a=%h b=%h want a=%h b=%h", k,
                 cap_a[k[1:0]], cap_b[k[1:0]], exp_a8[k[1:0]], exp_b8[k[1:0]]);
      else n_pass++;
    end
    n_total++;
    if (bus8.pass_count !== 32'd4 || bus8.fail_count !== 32'd0)
      $display("FAIL ideal_counts got pass=%0d fail=%0d want 4/0", bus8.pass_count, bus8.fail_count);
    else n_pass++;
    n_total++;
    if (bus8.all_pass !== 1'b1 || bus8.busy !== 1'b0)
      $display("FAIL ideal_flags got all_pass=%b busy=%b want 1/0", bus8.all_pass, bus8.busy);
    else n_pass++;
    n_total++;
    if (bus8.first_fail_idx !== 32'hFFFFFFFF || bus8.first_fail_sum !== 8'h00)
      $display("FAIL ideal_ff got idx=%h sum=%h want FFFFFFFF/00", bus8.first_fail_idx, bus8.first_fail_sum);
    else n_pass++;
  endtask

  task automatic test_done_hold();
    repeat (5) @(negedge clk);
    n_total++;
    if (bus8.done !== 1'b1 || bus8.pass_count !== 32'd4 || bus8.all_pass !== 1'b1)
      $display("FAIL done_hold got done=%b pass=%0d all_pass=%b want 1/4/1",
               bus8.done, bus8.pass_count, bus8.all_pass);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e;
    run8(-1, e);
    n_total++;
    if (e !== 17) $display("FAIL b2b_latency got %0d edges want 17", e); else n_pass++;
    n_total++;
    if (cap_a[0] !== 8'hFF || cap_b[3] !== 8'h80)
      $display("FAIL b2b_reseed got a0=%h b3=%h want FF/80", cap_a[0], cap_b[3]);
    else n_pass++;
    n_total++;
    if (bus8.pass_count !== 32'd4 || bus8.fail_count !== 32'd0)
      $display("FAIL b2b_counts got pass=%0d fail=%0d want 4/0", bus8.pass_count, bus8.fail_count);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int e;
    run8(9, e);
    n_total++;
    if (e !== 17) $display("FAIL ignored_latency got %0d edges want 17", e); else n_pass++;
    n_total++;
    if (bus8.pass_count !== 32'd4 || bus8.fail_count !== 32'd0 || bus8.all_pass !== 1'b1)
      $display("FAIL ignored_counts got pass=%0d fail=%0d all_pass=%b want 4/0/1",
               bus8.pass_count, bus8.fail_count, bus8.all_pass);
    else n_pass++;
    n_total++;
    if (cap_a[3] !== 8'hC0 || cap_b[3] !== 8'h80)
      $display("FAIL ignored_ops got a3=%h b3=%h want C0/80", cap_a[3], cap_b[3]);
    else n_pass++;
  endtask

  task automatic test_fault();
    int e;
    @(negedge clk); bus16.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus16.start = 1'b0;
    e = 0;
    while (bus16.done !== 1'b1 && e < 1000) begin
      @(posedge clk); e++;
      @(negedge clk);
    end
    n_total++;
    if (e !== 401) $display("FAIL fault_latency got %0d edges want 401", e); else n_pass++;
    n_total++;
    if (bus16.pass_count + bus16.fail_count !== 32'd100)
      $display("FAIL fault_total got %0d want 100", bus16.pass_count + bus16.fail_count);
    else n_pass++;
    // Vectors 1..28 have even true sums (no LFSR feedback yet); vector 0 is odd.
    n_total++;
    if (bus16.fail_count < 32'd28 || bus16.pass_count < 32'd1)
      $display("FAIL fault_counts got pass=%0d fail=%0d want pass>=1 fail>=28",
               bus16.pass_count, bus16.fail_count);
    else n_pass++;
    n_total++;
    if (bus16.first_fail_idx !== 32'd1)
      $display("FAIL fault_first_idx got %0d want 1", bus16.first_fail_idx);
    else n_pass++;
    n_total++;
    if (bus16.first_fail_sum !== 16'h003D)
      $display("FAIL fault_first_sum got %h want 003D", bus16.first_fail_sum);
    else n_pass++;
    n_total++;
    if (bus16.all_pass !== 1'b0 || bus16.done !== 1'b1)
      $display("FAIL fault_flags got all_pass=%b done=%b want 0/1", bus16.all_pass, bus16.done);
    else n_pass++;
  endtask

  task automatic test_seed_zero();
    int e;
    logic [63:0] ea [3];
    logic [63:0] eb [3];
    ea = '{64'h1, 64'h4, 64'h10};
    eb = '{64'h2, 64'h8, 64'h20};
    @(negedge clk); bus64.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus64.start = 1'b0;
    e = 0;
    while (bus64.done !== 1'b1 && e < 100) begin
      @(posedge clk); e++;
      @(negedge clk);
      // SETTLE_CYCLES=1: LOAD edges at 1, 4, 7.
      if (e % 3 == 1 && e < 10) begin
        n_total++;
        if (bus64.aut_a !== ea[(e/3)] || bus64.aut_b !== eb[(e/3)])
          $display("FAIL seed0_ops[%0d] got a=%h b=%h want a=%h b=%h", e / 3,
                   bus64.aut_a, bus64.aut_b, ea[(e/3)], eb[(e/3)]);
        else n_pass++;
      end
    end
    n_total++;
    if (e !== 10) $display("FAIL seed0_latency got %0d edges want 10", e); else n_pass++;
    n_total++;
    if (bus64.all_pass !== 1'b1 || bus64.pass_count !== 32'd3 || bus64.fail_count !== 32'd0)
      $display("FAIL seed0_result got all_pass=%b pass=%0d fail=%0d want 1/3/0",
               bus64.all_pass, bus64.pass_count, bus64.fail_count);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int e;
    @(negedge clk); bus8.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus8.start = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (bus8.pass_count !== 32'd3 || bus8.aut_a !== 8'hC0)
      $display("FAIL midrun_pre got pass=%0d a=%h want 3/C0", bus8.pass_count, bus8.aut_a);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if ({bus8.busy, bus8.done, bus8.all_pass} !== 3'b000 || {bus8.aut_a, bus8.aut_b} !== 16'h0)
      $display("FAIL midrun_reset_ctl got flags=%b ops=%h want 000/0000",
               {bus8.busy, bus8.done, bus8.all_pass}, {bus8.aut_a, bus8.aut_b});
    else n_pass++;
    n_total++;
    if (bus8.pass_count !== 32'd0 || bus8.fail_count !== 32'd0 || bus8.first_fail_idx !== 32'hFFFFFFFF)
      $display("FAIL midrun_reset_stats got pass=%0d fail=%0d ffi=%h want 0/0/FFFFFFFF",
               bus8.pass_count, bus8.fail_count, bus8.first_fail_idx);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cap_a[k[1:0]] = 8'h00;
      cap_b[k[1:0]] = 8'h00;
    end
    run8(-1, e);
    n_total++;
    if (e !== 17) $display("FAIL rerun_latency got %0d edges want 17", e); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (cap_a[k[1:0]] !== exp_a8[k[1:0]] || cap_b[k[1:0]] !== exp_b8[k[1:0]])
        $display("FAIL rerun_ops[%0d] got a=%h b=%h want a=%h b=%h", k,
                 cap_a[k[1:0]], cap_b[k[1:0]], exp_a8[k[1:0]], exp_b8[k[1:0]]);
      else n_pass++;
    end
    n_total++;
    if (bus8.pass_count !== 32'd4 || bus8.all_pass !== 1'b1)
      $display("FAIL rerun_result got pass=%0d all_pass=%b want 4/1", bus8.pass_count, bus8.all_pass);
    else n_pass++;
  endtask

  initial begin
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
    bus64.start = 1'b0;
    test_reset();
    test_ideal();
    test_done_hold();
    test_back_to_back();
    test_start_ignored();
    test_fault();
    test_seed_zero();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
